// File: rtl/debug_disp_pkg.sv
// Shared constants for the processor-board debug display: probe channel map
// and the packing helper for the PC/state probe word.
package debug_disp_pkg;

  localparam int CH_PC_STATE   = 0;
  localparam int CH_ALU_A      = 1;
  localparam int CH_ALU_B      = 2;
  localparam int CH_ALU_OUT    = 3;
  localparam int CH_NEXT_STATE = 4;

  // Keeps the high PC bits and the low PC nibble on separate hex digits, and
  // puts the FSM state on the rightmost digit.
  function automatic logic [15:0] pack_pc_state(input logic [6:0] pc, input logic [3:0] state);
    return {1'b0, pc[6:4], pc[3:0], 4'h0, state};
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Auto-scroll dwell counter: counts 0..DWELL-1 while enabled and pulses Step
// for one cycle on the wrap cycle. It is held at 0 whenever it is disabled.
module dwell_timer #(
  parameter int DWELL = 50_000_000
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic En,
  output logic Step
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] dwell_cnt;
  logic             at_end;

  assign at_end = (dwell_cnt == CNT_W'(DWELL - 1));
  assign Step   = En & at_end;

  always_ff @(posedge Clk) begin
    if (!ResetN || !En) begin
      dwell_cnt <= '0;
    end else if (at_end) begin
      dwell_cnt <= '0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_hex_mux.sv
// Registered debug-display selector. The shown channel comes from the
// switches or from the dwell timer, and Freeze toggles a snapshot of all probes.
module debug_hex_mux
  import debug_disp_pkg::*;
#(
  parameter int  NUM_CH     = 5,
  parameter int  DATA_W     = 16,
  parameter int  NUM_DIGITS = 4,
  parameter int  DWELL      = 50_000_000,
  localparam int IDX_W      = $clog2(NUM_CH)
) (
  input  logic                     Clk,
  input  logic                     ResetN,
  input  logic [IDX_W-1:0]         Sw,
  input  logic                     AutoMode,
  input  logic                     Freeze,
  input  logic [NUM_CH*DATA_W-1:0] Probe,
  output logic [4*NUM_DIGITS-1:0]  Hex,
  output logic [IDX_W-1:0]         ChIdx,
  output logic                     Frozen,
  output logic                     Valid
);

  localparam int HEX_W = 4 * NUM_DIGITS;

  logic [IDX_W-1:0]  idx;
  logic              freeze_q;
  logic              frozen_q;
  logic [DATA_W-1:0] snap [NUM_CH];
  logic [HEX_W-1:0]  hex_q;
  logic              valid_q;
  logic              step;
  logic              rise;
  logic              idx_ok;
  logic              idx_last;
  logic [HEX_W-1:0]  src_word;

  dwell_timer #(.DWELL(DWELL)) u_dwell (
    .Clk   (Clk),
    .ResetN(ResetN),
    .En    (AutoMode),
    .Step  (step)
  );

  // Compare one bit wider so a power-of-two NUM_CH does not truncate to 0.
  assign idx_ok   = ({1'b0, idx} <  (IDX_W + 1)'(NUM_CH));
  assign idx_last = ({1'b0, idx} >= (IDX_W + 1)'(NUM_CH - 1));
  assign rise     = Freeze & ~freeze_q;

  always_comb begin
    src_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (idx == IDX_W'(c)) begin
        src_word[DATA_W-1:0] = frozen_q ? snap[c] : Probe[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      idx      <= '0;
      freeze_q <= 1'b0;
      frozen_q <= 1'b0;
      hex_q    <= '0;
      valid_q  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) snap[c] <= '0;
    end else begin
      freeze_q <= Freeze;

      if (!AutoMode) begin
        idx <= Sw;
      end else if (step) begin
        idx <= idx_last ? '0 : idx + 1'b1;
      end

      // Snapshot and index stepping are independent and may share an edge.
      if (rise) begin
        if (!frozen_q) begin
          for (int c = 0; c < NUM_CH; c++) snap[c] <= Probe[c*DATA_W +: DATA_W];
          frozen_q <= 1'b1;
        end else begin
          frozen_q <= 1'b0;
        end
      end

      hex_q   <= idx_ok ? src_word : '0;
      valid_q <= idx_ok;
    end
  end

  assign Hex    = hex_q;
  assign ChIdx  = idx;
  assign Frozen = frozen_q;
  assign Valid  = valid_q;

endmodule

// File: tb/tb_debug_hex_mux.sv
// Self-checking bench for debug_hex_mux: directed vector table, hand-checked
// dwell/freeze corner sequences, and random traffic against a cycle model.
module tb_debug_hex_mux;
  import debug_disp_pkg::*;

  localparam int NCH = 5;
  localparam int DW  = 16;
  localparam int DWL = 4;

  logic        Clk;
  logic        ResetN;
  logic [2:0]  Sw;
  logic        AutoMode;
  logic        Freeze;
  logic [79:0] Probe;
  logic [15:0] Hex;
  logic [2:0]  ChIdx;
  logic        Frozen;
  logic        Valid;
  logic [15:0] probe_arr [NCH];

  logic        ResetN8;
  logic [0:0]  Sw8;
  logic        AutoMode8;
  logic        Freeze8;
  logic [15:0] Probe8;
  logic [15:0] Hex8;
  logic [0:0]  ChIdx8;
  logic        Frozen8;
  logic        Valid8;

  int total = 0;
  int bad   = 0;

  debug_hex_mux #(.NUM_CH(NCH), .DATA_W(DW), .NUM_DIGITS(4), .DWELL(DWL)) dut (
    .Clk(Clk), .ResetN(ResetN), .Sw(Sw), .AutoMode(AutoMode), .Freeze(Freeze),
    .Probe(Probe), .Hex(Hex), .ChIdx(ChIdx), .Frozen(Frozen), .Valid(Valid)
  );

  debug_hex_mux #(.NUM_CH(2), .DATA_W(8), .NUM_DIGITS(4), .DWELL(2)) dut8 (
    .Clk(Clk), .ResetN(ResetN8), .Sw(Sw8), .AutoMode(AutoMode8), .Freeze(Freeze8),
    .Probe(Probe8), .Hex(Hex8), .ChIdx(ChIdx8), .Frozen(Frozen8), .Valid(Valid8)
  );

  always_comb begin
    for (int c = 0; c < NCH; c++) Probe[c*DW +: DW] = probe_arr[c];
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Behavioural model state: channel shown, cycles spent in auto mode modulo
  // DWELL, freeze toggle state and the registered display outputs.
  int          m_idx, m_cnt;
  logic        m_frozen, m_fq, m_valid;
  logic [15:0] m_hex;
  logic [15:0] m_snap [NCH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    int          n_idx, n_cnt;
    logic        n_frozen, n_fq, n_valid;
    logic [15:0] n_hex;
    logic [15:0] n_snap [NCH];
    n_snap = m_snap;
    if (!ResetN) begin
      n_idx = 0; n_cnt = 0; n_frozen = 0; n_fq = 0; n_valid = 0; n_hex = 0;
      for (int c = 0; c < NCH; c++) n_snap[c] = 0;
    end else begin
      n_fq = Freeze;
      n_frozen = m_frozen;
      if (Freeze && !m_fq) begin
        if (!m_frozen) begin
          for (int c = 0; c < NCH; c++) n_snap[c] = probe_arr[c];
          n_frozen = 1;
        end else begin
          n_frozen = 0;
        end
      end
      if (!AutoMode) begin
        n_idx = int'(Sw);
        n_cnt = 0;
      end else if (m_cnt == DWL - 1) begin
        n_cnt = 0;
        n_idx = (m_idx >= NCH - 1) ? 0 : m_idx + 1;
      end else begin
        n_cnt = m_cnt + 1;
        n_idx = m_idx;
      end
      if (m_idx < NCH) begin
        n_hex   = m_frozen ? m_snap[m_idx] : probe_arr[m_idx];
        n_valid = 1;
      end else begin
        n_hex   = 0;
        n_valid = 0;
      end
    end
    @(posedge Clk);
    #1;
    m_idx = n_idx; m_cnt = n_cnt; m_frozen = n_frozen; m_fq = n_fq;
    m_valid = n_valid; m_hex = n_hex; m_snap = n_snap;
    chk("model_chidx",  32'(ChIdx),  32'(m_idx));
    chk("model_hex",    32'(Hex),    32'(m_hex));
    chk("model_valid",  32'(Valid),  32'(m_valid));
    chk("model_frozen", 32'(Frozen), 32'(m_frozen));
  endtask

  typedef struct {
    logic [2:0]  sw;
    logic        auto_m;
    logic        frz;
    logic [15:0] p3;
    logic [2:0]  e_idx;
    logic [15:0] e_hex;
    logic        e_valid;
    logic        e_frozen;
  } vec_t;

  vec_t        tbl [11];
  logic [15:0] rec [NCH];
  int          exp_i;

  initial begin
    tbl[0]  = '{3'd2, 1'b0, 1'b0, 16'h1234, 3'd2, 16'h5A03, 1'b1, 1'b0};
    tbl[1]  = '{3'd2, 1'b0, 1'b0, 16'h1234, 3'd2, 16'hBEEF, 1'b1, 1'b0};
    tbl[2]  = '{3'd6, 1'b0, 1'b0, 16'h1234, 3'd6, 16'hBEEF, 1'b1, 1'b0};
    tbl[3]  = '{3'd6, 1'b0, 1'b0, 16'h1234, 3'd6, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{3'd3, 1'b0, 1'b0, 16'h1234, 3'd3, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{3'd3, 1'b0, 1'b1, 16'h1234, 3'd3, 16'h1234, 1'b1, 1'b1};
    tbl[6]  = '{3'd3, 1'b0, 1'b1, 16'h5678, 3'd3, 16'h1234, 1'b1, 1'b1};
    tbl[7]  = '{3'd3, 1'b0, 1'b1, 16'h5678, 3'd3, 16'h1234, 1'b1, 1'b1};
    tbl[8]  = '{3'd3, 1'b0, 1'b0, 16'h5678, 3'd3, 16'h1234, 1'b1, 1'b1};
    tbl[9]  = '{3'd3, 1'b0, 1'b1, 16'h5678, 3'd3, 16'h1234, 1'b1, 1'b0};
    tbl[10] = '{3'd3, 1'b0, 1'b1, 16'h5678, 3'd3, 16'h5678, 1'b1, 1'b0};

    ResetN = 1'b0; Sw = '0; AutoMode = 1'b0; Freeze = 1'b0;
    probe_arr[CH_PC_STATE]   = pack_pc_state(7'h5A, 4'h3);
    probe_arr[CH_ALU_A]      = 16'hA001;
    probe_arr[CH_ALU_B]      = 16'hBEEF;
    probe_arr[CH_ALU_OUT]    = 16'h1234;
    probe_arr[CH_NEXT_STATE] = 16'hA004;
    ResetN8 = 1'b0; Sw8 = '0; AutoMode8 = 1'b0; Freeze8 = 1'b0; Probe8 = {8'h3C, 8'hA5};
    m_idx = 0; m_cnt = 0; m_frozen = 0; m_fq = 0; m_valid = 0; m_hex = 0;
    for (int c = 0; c < NCH; c++) m_snap[c] = 0;

    step();
    step();
    chk("rst_chidx", 32'(ChIdx), 32'd0);
    chk("rst_hex", 32'(Hex), 32'd0);
    chk("rst_valid", 32'(Valid), 32'd0);
    chk("rst_frozen", 32'(Frozen), 32'd0);
    ResetN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      Sw = tbl[i].sw; AutoMode = tbl[i].auto_m; Freeze = tbl[i].frz;
      probe_arr[CH_ALU_OUT] = tbl[i].p3;
      step();
      chk($sformatf("tbl%0d_chidx", i), 32'(ChIdx), 32'(tbl[i].e_idx));
      chk($sformatf("tbl%0d_hex", i), 32'(Hex), 32'(tbl[i].e_hex));
      chk($sformatf("tbl%0d_valid", i), 32'(Valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_frozen", i), 32'(Frozen), 32'(tbl[i].e_frozen));
    end

    // Out-of-range manual index, then auto: first step lands on 0 after DWELL.
    Freeze = 1'b0; Sw = 3'd6;
    step();
    step();
    AutoMode = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      step();
      exp_i = (n < DWL) ? 6 : ((n / DWL) - 1) % NCH;
      chk($sformatf("auto_idx_n%0d", n), 32'(ChIdx), 32'(exp_i));
    end

    // Freeze rise on the wrap cycle: step and snapshot share the edge.
    for (int k = 0; k < 2 * DWL && m_cnt != DWL - 1; k++) step();
    chk("wrap_reached", 32'(m_cnt), 32'(DWL - 1));
    for (int c = 0; c < NCH; c++) begin
      probe_arr[c] = 16'($urandom);
      rec[c] = probe_arr[c];
    end
    exp_i = (m_idx >= NCH - 1) ? 0 : m_idx + 1;
    Freeze = 1'b1;
    step();
    chk("wrap_idx", 32'(ChIdx), 32'(exp_i));
    chk("wrap_frozen", 32'(Frozen), 32'd1);
    Freeze = 1'b0;
    for (int c = 0; c < NCH; c++) probe_arr[c] = 16'($urandom);
    step();
    chk("wrap_snap_hex", 32'(Hex), 32'(rec[exp_i]));
    for (int k = 0; k < 12; k++) begin
      for (int c = 0; c < NCH; c++) probe_arr[c] = 16'($urandom);
      step();
    end

    // Unfreeze, snapshot 0..4, then auto-scroll shows only snapshot values.
    Freeze = 1'b1; step();
    Freeze = 1'b0; step();
    for (int c = 0; c < NCH; c++) probe_arr[c] = 16'(c);
    Freeze = 1'b1; step();
    Freeze = 1'b0;
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < NCH; c++) probe_arr[c] = 16'($urandom_range(16, 65535));
      step();
      chk("scroll_snap_range", 32'(Hex < 16'd5), 32'd1);
    end

    // Reset mid-freeze on channel 3.
    AutoMode = 1'b0; Sw = 3'd3;
    step();
    Freeze = 1'b1; step();
    chk("midrst_pre_frozen", 32'(Frozen), 32'(m_frozen));
    ResetN = 1'b0; step();
    chk("midrst_chidx", 32'(ChIdx), 32'd0);
    chk("midrst_hex", 32'(Hex), 32'd0);
    chk("midrst_frozen", 32'(Frozen), 32'd0);
    ResetN = 1'b1; Freeze = 1'b0;

    for (int k = 0; k < 400; k++) begin
      ResetN = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) AutoMode = ~AutoMode;
      Sw = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) Freeze = ~Freeze;
      for (int c = 0; c < NCH; c++) probe_arr[c] = 16'($urandom);
      step();
    end

    // Narrow-word variant: 8-bit probes zero-extend to four digits.
    ResetN8 = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    chk("w8_ch0_hex", 32'(Hex8), 32'h00A5);
    chk("w8_ch0_valid", 32'(Valid8), 32'd1);
    Sw8 = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    chk("w8_ch1_hex", 32'(Hex8), 32'h003C);
    chk("w8_ch1_idx", 32'(ChIdx8), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_hex_mux.md
# debug_hex_mux

Parametrised, registered debug-display selector for the 16-bit processor board. It takes NUM_CH packed probe words and drives NUM_DIGITS hex nibbles to the seven-segment decoders. The channel shown comes from the switches (manual mode) or from a dwell timer that steps through the channels (auto mode). A freeze toggle snapshots every channel at the same instant, so the user can browse one consistent machine state.

## Interface
- NUM_CH, 5, number of probe channels; must be ≥ 2.
- DATA_W, 16, width of each probe word; must be ≤ 4*NUM_DIGITS.
- NUM_DIGITS, 4, number of hex digits driven.
- DWELL, 50_000_000, clock cycles per channel in auto mode; must be ≥ 2.
- IDX_W (localparam), $clog2(NUM_CH), channel index width.
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  synchronous, active-low reset.
- Sw  input  IDX_W  manual channel select.
- AutoMode  input  1  1 = auto-scroll, 0 = manual.
- Freeze  input  1  freeze toggle request, level; already synchronised and debounced upstream.
- Probe  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- Hex  output  4*NUM_DIGITS  digit d is [4d +: 4]; the most significant digit is leftmost.
- ChIdx  output  IDX_W  channel index currently displayed.
- Frozen  output  1  snapshot mode active.
- Valid  output  1  ChIdx < NUM_CH.

## Operation
- Registers:
  - Idx
  - DwellCnt
  - FreezeQ (previous Freeze)
  - Frozen
  - Snap[NUM_CH] (DATA_W each)
  - Hex
  - Valid
- Reset (ResetN = 0 at a rising edge) clears all of the above to 0. Reset mid-freeze or mid-dwell discards the snapshot and the count.
- Manual mode (AutoMode = 0):
  - Idx <= Sw every cycle.
  - DwellCnt held at 0.
- Auto mode (AutoMode = 1):
  - DwellCnt counts 0..DWELL-1, then wraps to 0.
  - On the wrap cycle, Idx <= (Idx ≥ NUM_CH-1) ? 0 : Idx+1.
  - An out-of-range Idx therefore steps to 0.
  - On the first auto cycle, Idx keeps its manual value and DwellCnt starts from 0.
- Freeze:
  - Rise = Freeze & ~FreezeQ.
  - Rise while Frozen = 0: all Snap[c] <= Probe channel c, and Frozen <= 1 on the same edge.
  - Rise while Frozen = 1: Frozen <= 0; Snap keeps its contents.
  - A held Freeze level does nothing further.
- Source word: Frozen ? Snap[Idx] : live Probe[Idx].
  - Zero-extended on the left to 4*NUM_DIGITS bits.
- Hex <= source word when Idx < NUM_CH, else 0.
- Valid <= (Idx < NUM_CH).
- ChIdx = Idx, direct.
- Index selection and freeze are independent. A dwell step and a freeze rise in the same cycle both take effect.

## Timing
- Sw change to ChIdx: 1 cycle. Sw change to Hex/Valid: 2 cycles.
- Live Probe change to Hex: 1 cycle.
- Freeze rise at edge N:
  - Frozen = 1 after edge N.
  - Hex shows snapshot data after edge N+1.
  - The snapshot holds Probe as sampled at edge N.
- Auto step: Idx changes every DWELL cycles exactly. Hex follows 1 cycle later.
- First cycle after reset release: Hex = 0, Valid = 0, ChIdx = 0. Channel 0 appears one edge later.

## Structure
- Package debug_disp_pkg holds:
  - Processor channel constants: CH_PC_STATE = 0, CH_ALU_A = 1, CH_ALU_B = 2, CH_ALU_OUT = 3, CH_NEXT_STATE = 4.
  - A pack_pc_state function: {1'b0, PC[6:4], PC[3:0], 4'h0, State} packed into 16 bits.
- Sub-module dwell_timer (params DWELL; ports Clk, ResetN, En, Step):
  - Owns DwellCnt.
  - Step is a one-cycle pulse on the wrap cycle.
  - Clears when En = 0.
- Snapshot bank and selection live in debug_hex_mux.

## Test plan
- Reset, then Sw = 2, manual, Probe ch2 = 16'hBEEF -> ChIdx = 2 after 1 cycle; Hex = 16'hBEEF, Valid = 1 after 2 cycles.
- Sw = 6 with NUM_CH = 5 -> Hex = 0, Valid = 0, ChIdx = 6. Then AutoMode = 1, DWELL = 4 -> Idx goes to 0 after 4 cycles and then steps 0,1,2,3,4,0 every 4 cycles.
- Freeze rise with ch3 = 16'h1234, then ch3 changed to 16'h5678 -> Frozen = 1, Hex stays 16'h1234 while Freeze is held. A second rise -> Hex = 16'h5678 two cycles later.
- Frozen with auto-scroll over channels 0..4 holding 16'h0000..0004 at freeze time, while Probe keeps changing -> Hex cycles through the snapshot values only.
- Freeze rise coinciding with the dwell wrap cycle -> Idx increments and Frozen sets on the same edge; the snapshot equals Probe at that edge.
- ResetN low for 1 cycle mid-freeze with Idx = 3 -> Frozen = 0, Hex = 0, ChIdx = 0. DATA_W = 8, NUM_DIGITS = 4 variant with ch0 = 8'hA5 -> Hex = 16'h00A5.
